// File: rtl/tx_pkg.sv
// Shared state encoding, default parameters and a width helper for the
// serial pattern transmitter.
package tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } tx_state_t;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DIV   = 4;
  localparam int DEF_GAP   = 1;

  // Counter width for a modulus of n, never narrower than one bit.
  function automatic int min_one_clog2(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bit_tick_gen.sv
// DIV-cycle bit timer. tick marks the last cycle of a bit, bit_start the
// first; restart forces the next cycle to be the first cycle of a bit.
module bit_tick_gen
  import tx_pkg::*;
#(
  parameter int DIV = DEF_DIV
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic tick,
  output logic bit_start
);

  localparam int TW = min_one_clog2(DIV);

  logic [TW-1:0] cnt_q;

  assign tick      = (cnt_q == TW'(DIV - 1));
  assign bit_start = (cnt_q == '0);

  // Count 0..DIV-1, wrapping at the tick or on restart.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (restart || tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + TW'(1);
    end
  end

endmodule

// File: rtl/serial_pattern_tx.sv
// Serial pattern transmitter: accepts a WIDTH-bit word over valid/ready and
// shifts it out MSB-first on w, DIV clocks per bit, with optional repeats,
// zero gap bits between repeats and a latched stop request.
module serial_pattern_tx
  import tx_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DIV   = DEF_DIV,
  parameter int GAP   = DEF_GAP
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [3:0]       repeat_n,
  input  logic             stop,
  output logic             w,
  output logic             bit_strobe,
  output logic             busy,
  output logic             done
);

  localparam int BW = min_one_clog2(WIDTH);
  localparam int GW = min_one_clog2(GAP);

  tx_state_t        state_q, state_d;
  logic [WIDTH-1:0] shreg_q;
  logic [WIDTH-1:0] hold_q;
  logic [BW-1:0]    bit_idx_q;
  logic [GW-1:0]    gap_cnt_q;
  logic [3:0]       rem_q;
  logic             cont_q;
  logic             stop_q;
  logic             ready_q;
  logic             done_q;

  logic accept;
  logic busy_int;
  logic stop_eff;
  logic more;
  logic word_end;
  logic gap_end;
  logic reload;
  logic finish;
  logic restart;
  logic tick;
  logic bit_start;

  assign accept   = load_valid && ready_q && (state_q == ST_IDLE);
  assign busy_int = (state_q != ST_IDLE);
  // A stop seen on the deciding cycle counts as well as an earlier latched one.
  assign stop_eff = stop_q || stop;
  assign more     = cont_q || (rem_q > 4'd1);
  assign word_end = (state_q == ST_SHIFT) && tick && (bit_idx_q == BW'(WIDTH - 1));
  assign gap_end  = (state_q == ST_GAP) && tick && (gap_cnt_q == '0);
  assign restart  = (state_q == ST_IDLE) || (state_d != state_q) || reload;

  bit_tick_gen #(
    .DIV(DIV)
  ) u_tick (
    .clk      (clk),
    .reset    (reset),
    .restart  (restart),
    .tick     (tick),
    .bit_start(bit_start)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode, word reload and completion decisions.
  always_comb begin
    state_d = state_q;
    reload  = 1'b0;
    finish  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (word_end) begin
          if (more && !stop_eff) begin
            if (GAP > 0) begin
              state_d = ST_GAP;
            end else begin
              reload = 1'b1;
            end
          end else begin
            state_d = ST_IDLE;
            finish  = 1'b1;
          end
        end
      end
      ST_GAP: begin
        if (stop_eff) begin
          state_d = ST_IDLE;
          finish  = 1'b1;
        end else if (gap_end) begin
          state_d = ST_SHIFT;
          reload  = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Datapath: shift register, hold copy, bit/gap/repeat counters, stop latch
  // and the registered ready/done outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shreg_q   <= '0;
      hold_q    <= '0;
      bit_idx_q <= '0;
      gap_cnt_q <= '0;
      rem_q     <= '0;
      cont_q    <= 1'b0;
      stop_q    <= 1'b0;
      ready_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      ready_q <= (state_d == ST_IDLE);
      done_q  <= finish;

      if (accept) begin
        stop_q <= stop;
      end else if (busy_int) begin
        stop_q <= stop_q || stop;
      end else begin
        stop_q <= 1'b0;
      end

      if (accept) begin
        shreg_q   <= data_in;
        hold_q    <= data_in;
        bit_idx_q <= '0;
      end else if (reload) begin
        shreg_q   <= hold_q;
        bit_idx_q <= '0;
      end else if (word_end) begin
        bit_idx_q <= '0;
      end else if ((state_q == ST_SHIFT) && tick) begin
        shreg_q   <= {shreg_q[WIDTH-2:0], 1'b0};
        bit_idx_q <= bit_idx_q + BW'(1);
      end

      if (accept) begin
        rem_q  <= repeat_n;
        cont_q <= (repeat_n == 4'd0);
      end else if (word_end && !cont_q) begin
        rem_q <= rem_q - 4'd1;
      end

      if ((state_d == ST_GAP) && (state_q != ST_GAP)) begin
        gap_cnt_q <= GW'((GAP > 0) ? GAP - 1 : 0);
      end else if ((state_q == ST_GAP) && tick && (gap_cnt_q != '0)) begin
        gap_cnt_q <= gap_cnt_q - GW'(1);
      end
    end
  end

  assign load_ready = ready_q;
  assign w          = (state_q == ST_SHIFT) && shreg_q[WIDTH-1];
  assign bit_strobe = busy_int && bit_start;
  assign busy       = busy_int;
  assign done       = done_q;

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Bench for serial_pattern_tx: three instances with different DIV/GAP, a
// queue-based stream model built from the word/repeat/gap/stop rules, and
// directed plus randomized transactions.
module tb_serial_pattern_tx;

  localparam int WIDTH = 8;
  localparam int NDUT  = 3;

  logic             clk;
  logic             reset;
  logic [WIDTH-1:0] dut_data  [NDUT];
  logic             dut_valid [NDUT];
  logic [3:0]       dut_rep   [NDUT];
  logic             dut_stop  [NDUT];
  logic             dut_ready [NDUT];
  logic             dut_w     [NDUT];
  logic             dut_strb  [NDUT];
  logic             dut_busy  [NDUT];
  logic             dut_done  [NDUT];

  int n_checks;
  int n_fail;

  bit exp_w[$];
  bit exp_s[$];
  bit obs_bits[$];

  serial_pattern_tx #(.WIDTH(WIDTH), .DIV(1), .GAP(0)) u_dut0 (
    .clk(clk), .reset(reset), .data_in(dut_data[0]), .load_valid(dut_valid[0]),
    .load_ready(dut_ready[0]), .repeat_n(dut_rep[0]), .stop(dut_stop[0]),
    .w(dut_w[0]), .bit_strobe(dut_strb[0]), .busy(dut_busy[0]), .done(dut_done[0])
  );

  serial_pattern_tx #(.WIDTH(WIDTH), .DIV(4), .GAP(1)) u_dut1 (
    .clk(clk), .reset(reset), .data_in(dut_data[1]), .load_valid(dut_valid[1]),
    .load_ready(dut_ready[1]), .repeat_n(dut_rep[1]), .stop(dut_stop[1]),
    .w(dut_w[1]), .bit_strobe(dut_strb[1]), .busy(dut_busy[1]), .done(dut_done[1])
  );

  serial_pattern_tx #(.WIDTH(WIDTH), .DIV(1), .GAP(2)) u_dut2 (
    .clk(clk), .reset(reset), .data_in(dut_data[2]), .load_valid(dut_valid[2]),
    .load_ready(dut_ready[2]), .repeat_n(dut_rep[2]), .stop(dut_stop[2]),
    .w(dut_w[2]), .bit_strobe(dut_strb[2]), .busy(dut_busy[2]), .done(dut_done[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int div_of(input int idx);
    return (idx == 1) ? 4 : 1;
  endfunction

  function automatic int gap_of(input int idx);
    return (idx == 0) ? 0 : ((idx == 1) ? 1 : 2);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Expected stream: words of WIDTH bits held div cycles each, zero gaps of
  // gap*div cycles between words; stop seen by the last cycle of a word ends
  // after that word, stop seen inside a gap ends after that gap cycle.
  task automatic build_model(input int div, input int gap, input logic [WIDTH-1:0] word,
                             input int rep, input int stop_cycle);
    int  words;
    bit  stopped;
    exp_w.delete();
    exp_s.delete();
    words   = 0;
    stopped = 1'b0;
    forever begin
      words++;
      for (int b = WIDTH - 1; b >= 0; b--) begin
        for (int d = 0; d < div; d++) begin
          exp_w.push_back(word[b]);
          exp_s.push_back(d == 0);
        end
      end
      stopped = (stop_cycle >= 0) && (stop_cycle <= exp_w.size());
      if (stopped || (rep != 0 && words >= rep) || words >= 64) break;
      for (int g = 0; g < gap * div; g++) begin
        exp_w.push_back(1'b0);
        exp_s.push_back((g % div) == 0);
        if (stop_cycle == exp_w.size()) begin
          stopped = 1'b1;
          break;
        end
      end
      if (stopped) break;
    end
  endtask

  task automatic do_accept(input int idx, input logic [WIDTH-1:0] word,
                           input logic [3:0] rep, input int stop_cycle);
    int waited;
    waited = 0;
    while (dut_ready[idx] !== 1'b1 && waited < 200) begin
      @(posedge clk); #1;
      waited++;
    end
    check("accept_wait", (waited < 200), 1);
    dut_data[idx]  = word;
    dut_rep[idx]   = rep;
    dut_valid[idx] = 1'b1;
    dut_stop[idx]  = (stop_cycle == 0);
    @(posedge clk); #1;
    dut_valid[idx] = 1'b0;
    dut_stop[idx]  = 1'b0;
    dut_data[idx]  = WIDTH'($urandom);
    dut_rep[idx]   = 4'($urandom);
  endtask

  // Walks cycles 1..N+1 after an accept, comparing against the model.
  task automatic check_stream(input int idx, input int stop_cycle,
                              output int busy_cnt, output int strobe_cnt);
    int n;
    n          = exp_w.size();
    busy_cnt   = 0;
    strobe_cnt = 0;
    obs_bits.delete();
    for (int c = 1; c <= n + 1; c++) begin
      dut_stop[idx] = (c == stop_cycle);
      if (dut_busy[idx] === 1'b1) busy_cnt++;
      if (dut_strb[idx] === 1'b1) begin
        strobe_cnt++;
        obs_bits.push_back(dut_w[idx]);
      end
      if (c <= n) begin
        check($sformatf("w[d%0d c%0d]", idx, c), dut_w[idx], exp_w[c-1]);
        check($sformatf("strobe[d%0d c%0d]", idx, c), dut_strb[idx], exp_s[c-1]);
        check($sformatf("busy[d%0d c%0d]", idx, c), dut_busy[idx], 1);
        check($sformatf("done_early[d%0d c%0d]", idx, c), dut_done[idx], 0);
        check($sformatf("ready_busy[d%0d c%0d]", idx, c), dut_ready[idx], 0);
      end else begin
        check($sformatf("w_end[d%0d]", idx), dut_w[idx], 0);
        check($sformatf("busy_end[d%0d]", idx), dut_busy[idx], 0);
        check($sformatf("done_pulse[d%0d c%0d]", idx, c), dut_done[idx], 1);
        check($sformatf("ready_end[d%0d]", idx), dut_ready[idx], 1);
      end
      @(posedge clk); #1;
    end
    dut_stop[idx] = 1'b0;
  endtask

  function automatic int count_0011();
    int n = 0;
    for (int i = 3; i < obs_bits.size(); i++) begin
      if (!obs_bits[i-3] && !obs_bits[i-2] && obs_bits[i-1] && obs_bits[i]) n++;
    end
    return n;
  endfunction

  task automatic run_txn(input int idx, input logic [WIDTH-1:0] word, input int rep,
                         input int stop_cycle, output int busy_cnt, output int strobe_cnt);
    build_model(div_of(idx), gap_of(idx), word, rep, stop_cycle);
    do_accept(idx, word, 4'(rep), stop_cycle);
    check_stream(idx, stop_cycle, busy_cnt, strobe_cnt);
    check($sformatf("busy_len[d%0d]", idx), busy_cnt, exp_w.size());
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bc, sc, per, stop_c, rep, idx;
    logic [WIDTH-1:0] word;

    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b0;
    for (int i = 0; i < NDUT; i++) begin
      dut_data[i]  = '0;
      dut_valid[i] = 1'b0;
      dut_rep[i]   = '0;
      dut_stop[i]  = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < NDUT; i++) begin
      check($sformatf("rst_ready[d%0d]", i), dut_ready[i], 0);
      check($sformatf("rst_w[d%0d]", i), dut_w[i], 0);
      check($sformatf("rst_busy[d%0d]", i), dut_busy[i], 0);
      check($sformatf("rst_done[d%0d]", i), dut_done[i], 0);
      check($sformatf("rst_strobe[d%0d]", i), dut_strb[i], 0);
    end
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < NDUT; i++) begin
      check($sformatf("ready_after_rst[d%0d]", i), dut_ready[i], 1);
    end

    // Single word, DIV=1, GAP=0, and the 0011 detections it carries.
    run_txn(0, 8'b0011_0011, 1, -1, bc, sc);
    check("detect_0011", count_0011(), 2);
    check("single_busy", bc, 8);

    // Bit pacing with DIV=4.
    run_txn(1, 8'hA5, 1, -1, bc, sc);
    check("pace_busy", bc, 32);
    check("pace_strobes", sc, 8);

    // Repeats with a two-bit gap: 28 busy cycles, done on cycle 29.
    run_txn(2, 8'hF0, 3, -1, bc, sc);
    check("rep_gap_busy", bc, 28);
    check("rep_gap_strobes", sc, 28);

    // Continuous mode, stop during bit 3 of word 5.
    run_txn(1, 8'h5B, 0, 4 * 36 + 9, bc, sc);
    check("cont_stop_busy", bc, 5 * 32 + 4 * 4);
    check("cont_stop_strobes", sc, 5 * 8 + 4);

    // Maximum repeat count and stop coinciding with the accept.
    run_txn(0, 8'h81, 15, -1, bc, sc);
    check("rep15_busy", bc, 15 * 8);
    run_txn(2, 8'hC7, 5, 0, bc, sc);
    check("stop_at_accept_busy", bc, 8);

    // Held load_valid: no recapture while busy, next accept on the done cycle.
    build_model(1, 0, 8'h96, 1, -1);
    do_accept(0, 8'h96, 4'd1, -1);
    dut_data[0]  = 8'h3C;
    dut_rep[0]   = 4'd1;
    dut_valid[0] = 1'b1;
    check_stream(0, -1, bc, sc);
    dut_valid[0] = 1'b0;
    build_model(1, 0, 8'h3C, 1, -1);
    check_stream(0, -1, bc, sc);
    check("handshake_second_busy", bc, 8);

    // Reset during bit 4 aborts at once without a done pulse.
    build_model(4, 1, 8'hC3, 1, -1);
    do_accept(1, 8'hC3, 4'd1, -1);
    for (int c = 1; c <= 13; c++) begin
      check($sformatf("pre_rst_w[c%0d]", c), dut_w[1], exp_w[c-1]);
      @(posedge clk); #1;
    end
    #1 reset = 1'b0;
    #1;
    check("abort_w", dut_w[1], 0);
    check("abort_busy", dut_busy[1], 0);
    check("abort_strobe", dut_strb[1], 0);
    check("abort_done", dut_done[1], 0);
    check("abort_ready", dut_ready[1], 0);
    @(posedge clk); #1;
    check("abort_done_hold", dut_done[1], 0);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    check("ready_after_abort", dut_ready[1], 1);
    check("no_done_after_abort", dut_done[1], 0);
    run_txn(1, 8'h69, 2, -1, bc, sc);

    // Randomized transactions across all three configurations.
    for (int t = 0; t < 30; t++) begin
      idx  = $urandom_range(0, NDUT - 1);
      word = WIDTH'($urandom);
      rep  = $urandom_range(0, 4);
      if ((t % 10) == 3) rep = 15;
      per  = (WIDTH + gap_of(idx)) * div_of(idx);
      if (rep == 0) begin
        stop_c = $urandom_range(0, per * 4);
      end else if ($urandom_range(0, 1) == 0) begin
        stop_c = -1;
      end else begin
        stop_c = $urandom_range(0, per * rep);
      end
      run_txn(idx, word, rep, stop_c, bc, sc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_pattern_tx.md
Name: serial_pattern_tx

Overview:
- Serial bit-stream transmitter for the sequence-detector datapath. It drives the serial input `w` that the Mealy detectors sample.
- A WIDTH-bit pattern word is loaded through a valid/ready handshake and shifted out MSB-first, one bit per DIV clk cycles.
- Supports an optional repeat count, inter-word gap bits and a stop request.
- Bit pacing uses an internal tick enable, not a derived clock, so the whole block runs on the single clk domain.

Parameters:
- WIDTH, 8, pattern word length in bits (>=2).
- DIV, 4, clk cycles each bit is held on w (>=1; 1 means one bit per clk).
- GAP, 1, number of 0-bits inserted between repeated words (>=0). No gap is inserted after the last word.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- data_in  input  WIDTH  pattern word, captured on handshake.
- load_valid  input  1  data_in and repeat_n are valid.
- load_ready  output  1  block can accept a word (IDLE only).
- repeat_n  input  4  number of word transmissions; 0 = continuous until stop.
- stop  input  1  request to end continuous or repeated transmission.
- w  output  1  serial bit stream.
- bit_strobe  output  1  one-clk pulse on the first cycle of every transmitted bit, including gap bits.
- busy  output  1  high in SHIFT or GAP.
- done  output  1  one-clk pulse when transmission completes.

Behaviour:
- Reset values (asynchronous on reset=0):
  - state=IDLE.
  - w=0, bit_strobe=0, busy=0, done=0, load_ready=0.
  - All counters and the shift register cleared.
- First cycle after reset release: load_ready rises to 1.
- States and transitions:
  - IDLE: load_ready=1, w=0.
    - On a clk edge with load_valid&&load_ready: capture data_in into both the shift register and a hold copy, capture repeat_n into the remaining-repeat counter, then go to SHIFT.
    - load_ready=0 while in SHIFT or GAP; load_valid is ignored there.
  - SHIFT:
    - The first cycle after the accepting edge has w=data_in[WIDTH-1], bit_strobe=1, busy=1. Accept-to-first-bit latency is 1 clk.
    - A bit timer counts 0..DIV-1. On the last count the shift register shifts left and the next bit is presented with bit_strobe=1.
    - After WIDTH bits (WIDTH*DIV cycles), decrement the remaining count, unless continuous mode (repeat_n=0) is active.
    - If more words remain and stop has not been latched: go to GAP when GAP>0, otherwise go directly to SHIFT reloaded from the hold copy.
    - Otherwise: go to IDLE with done=1 for that first IDLE cycle. load_ready=1 in that same cycle.
  - GAP:
    - w=0 for GAP*DIV cycles, with bit_strobe at each gap-bit start.
    - Then reload from the hold copy and return to SHIFT.
- stop handling:
  - stop is latched while busy.
  - The current word always completes.
  - Any pending gap and repeats are skipped, then done pulses.
  - stop in IDLE has no effect. stop asserted in the same cycle as an accept is latched.
- Repeat count:
  - repeat_n=1 sends exactly one word.
  - repeat_n=15 sends 15 words.
  - With repeat_n=0, only stop terminates transmission.
- Reset mid-operation: the transmission is aborted immediately and no done pulse is produced. w is forced to 0 asynchronously.
- Width rules:
  - Bit index counter is $clog2(WIDTH) bits.
  - Bit timer is $clog2(DIV) bits (minimum 1).
  - Gap counter counts GAP-1 down to 0.
  - No counter wraps without a state change.

Decomposition:
- Shared package tx_pkg holds:
  - State encoding typedef with IDLE, SHIFT, GAP.
  - Default parameter constants.
- One natural sub-module, bit_tick_gen: a DIV-cycle enable counter with a synchronous restart input, producing the per-bit tick. It is restarted on each accept and each state entry.

Test Plan:
- Single word, DIV=1, GAP=0: load 8'b00110011 with repeat_n=1.
  - w=0,0,1,1,0,0,1,1 on cycles 1..8 after accept.
  - done pulses on cycle 9.
  - When w is fed to the 0011 Mealy detector, it reports exactly 2 detections.
- Bit pacing, DIV=4: load 8'hA5.
  - Each bit is held 4 cycles.
  - bit_strobe is high every 4th cycle, 8 pulses total.
  - busy is high for exactly 32 cycles.
- Repeats with gap, DIV=1, GAP=2: load 8'hF0 with repeat_n=3.
  - Stream is F0, 00, F0, 00, F0: 28 bits.
  - done pulses on cycle 29.
- Continuous with stop: repeat_n=0, assert stop during bit 3 of word 5.
  - Word 5 completes.
  - No gap follows.
  - done pulses; exactly 5 words are sent.
- Reset mid-shift: drive reset=0 during bit 4.
  - w, busy, bit_strobe and done are 0 immediately, with no done pulse.
  - load_ready is 1 one cycle after release, and a new load works normally.
- Handshake: hold load_valid high while busy.
  - The word is not recaptured.
  - The next accept occurs on the done cycle, and the first bit appears one cycle later.
